// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round controller.
// Card values use 1=A .. 13=K; hand scores are 0..9.
package baccarat_pkg;

  localparam int CARD_W  = 4;
  localparam int NATURAL = 8;

  typedef enum logic [2:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    EVAL_P,
    EVAL_D,
    DONE
  } deal_state_t;

  // Tens and face cards count as zero.
  function automatic logic [CARD_W-1:0] card_score(
    input logic [CARD_W-1:0] value
  );
    return (value >= CARD_W'(10)) ? '0 : value;
  endfunction

endpackage

// File: rtl/deal_sequencer_draw.sv
// Dealer third-card table: decides whether the banker draws,
// given the banker score and the player's third card.
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [CARD_W-1:0] dscore,
  input  logic [CARD_W-1:0] pcard3,
  output logic              draw
);

  logic [CARD_W-1:0] v;

  always_comb begin
    v    = card_score(pcard3);
    draw = 1'b0;
    case (dscore)
      CARD_W'(0),
      CARD_W'(1),
      CARD_W'(2): draw = 1'b1;
      CARD_W'(3): draw = (v != CARD_W'(8));
      CARD_W'(4): draw = (v >= CARD_W'(2)) && (v <= CARD_W'(7));
      CARD_W'(5): draw = (v >= CARD_W'(4)) && (v <= CARD_W'(7));
      CARD_W'(6): draw = (v >= CARD_W'(6)) && (v <= CARD_W'(7));
      default:    draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round FSM: sequences card loads one per user step,
// applies third-card rules and drives the win lights.
module deal_sequencer
  import baccarat_pkg::*;
(
  input  logic              slow_clock,
  input  logic              reset,
  input  logic              step,
  input  logic [CARD_W-1:0] pscore,
  input  logic [CARD_W-1:0] dscore,
  input  logic [CARD_W-1:0] pcard3,
  output logic              load_pcard1,
  output logic              load_pcard2,
  output logic              load_pcard3,
  output logic              load_dcard1,
  output logic              load_dcard2,
  output logic              load_dcard3,
  output logic              player_win_light,
  output logic              dealer_win_light,
  output logic              done
);

  deal_state_t state_q, state_d;
  logic [5:0]  load_q, load_d;
  logic        pwin_q, pwin_d;
  logic        dwin_q, dwin_d;
  logic        done_q, done_d;
  logic        step_ok;
  logic        dealer_draw;

  dealer_draw_rule u_draw (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (dealer_draw)
  );

  // A step during a load cycle is dropped so scores settle first.
  assign step_ok = step & ~(|load_q);

  always_comb begin
    state_d = state_q;
    load_d  = '0;
    pwin_d  = 1'b0;
    dwin_d  = 1'b0;
    case (state_q)
      DEAL_P1: if (step_ok) begin
        load_d[5] = 1'b1;
        state_d   = DEAL_D1;
      end
      DEAL_D1: if (step_ok) begin
        load_d[2] = 1'b1;
        state_d   = DEAL_P2;
      end
      DEAL_P2: if (step_ok) begin
        load_d[4] = 1'b1;
        state_d   = DEAL_D2;
      end
      DEAL_D2: if (step_ok) begin
        load_d[1] = 1'b1;
        state_d   = EVAL_P;
      end
      EVAL_P: if (step_ok) begin
        state_d = DONE;
        if (pscore >= CARD_W'(NATURAL) ||
            dscore >= CARD_W'(NATURAL)) begin
          load_d = '0;
        end else if (pscore <= CARD_W'(5)) begin
          load_d[3] = 1'b1;
          state_d   = EVAL_D;
        end else if (dscore <= CARD_W'(5)) begin
          load_d[0] = 1'b1;
        end
      end
      EVAL_D: if (step_ok) begin
        load_d[0] = dealer_draw;
        state_d   = DONE;
      end
      DONE: begin
        pwin_d = (pscore >= dscore);
        dwin_d = (dscore >= pscore);
      end
      default: state_d = DEAL_P1;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= DEAL_P1;
      load_q  <= '0;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
      done_q  <= done_d;
    end
  end

  assign load_pcard1      = load_q[5];
  assign load_pcard2      = load_q[4];
  assign load_pcard3      = load_q[3];
  assign load_dcard1      = load_q[2];
  assign load_dcard2      = load_q[1];
  assign load_dcard3      = load_q[0];
  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;
  assign done             = done_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: deal order, third-card
// rules, win lights, dropped steps and mid-deal reset.
module tb_deal_sequencer;
  import baccarat_pkg::*;

  logic              slow_clock = 1'b0;
  logic              reset = 1'b1;
  logic              step = 1'b0;
  logic [CARD_W-1:0] pscore = '0;
  logic [CARD_W-1:0] dscore = '0;
  logic [CARD_W-1:0] pcard3 = '0;
  logic lp1, lp2, lp3, ld1, ld2, ld3;
  logic pwin, dwin, done;
  logic [5:0] loads;

  int n_run = 0;
  int n_fail = 0;

  localparam logic [5:0] L_P1 = 6'b100000;
  localparam logic [5:0] L_P2 = 6'b010000;
  localparam logic [5:0] L_P3 = 6'b001000;
  localparam logic [5:0] L_D1 = 6'b000100;
  localparam logic [5:0] L_D2 = 6'b000010;
  localparam logic [5:0] L_D3 = 6'b000001;
  localparam logic [5:0] L_NONE = 6'b000000;

  deal_sequencer dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .step             (step),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .player_win_light (pwin),
    .dealer_win_light (dwin),
    .done             (done)
  );

  assign loads = {lp1, lp2, lp3, ld1, ld2, ld3};

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // One accepted step: check the one-cycle load, then quiet.
  task automatic pulse(input string tag, input logic [5:0] exp);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk({tag, "_load"}, 8'(loads), 8'(exp));
    tick();
    chk({tag, "_clr"}, 8'(loads), 8'(L_NONE));
    tick();
  endtask

  task automatic deal4();
    pulse("p1", L_P1);
    pulse("d1", L_D1);
    pulse("p2", L_P2);
    pulse("d2", L_D2);
  endtask

  initial begin
    do_reset();
    chk("rst_loads", 8'(loads), 8'(L_NONE));
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_lights", 8'({pwin, dwin}), 8'd0);

    // 1-2: initial deal, then player natural
    deal4();
    chk("deal_done", 8'(done), 8'd0);
    chk("deal_lights", 8'({pwin, dwin}), 8'd0);
    pscore = 4'd8;
    dscore = 4'd3;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("nat_load", 8'(loads), 8'(L_NONE));
    chk("nat_done", 8'(done), 8'd1);
    tick();
    chk("nat_lights", 8'({pwin, dwin}), 8'b10);
    pulse("done_ign", L_NONE);
    chk("done_hold", 8'(done), 8'd1);

    // 3: player draws, dealer 6 vs pcard3=7 draws, tie
    do_reset();
    chk("r3_done", 8'(done), 8'd0);
    chk("r3_lights", 8'({pwin, dwin}), 8'd0);
    deal4();
    pscore = 4'd4;
    dscore = 4'd6;
    pulse("p3", L_P3);
    chk("p3_done", 8'(done), 8'd0);
    pcard3 = 4'd7;
    pscore = 4'd9;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("d6v7_load", 8'(loads), 8'(L_D3));
    chk("d6v7_done", 8'(done), 8'd1);
    dscore = 4'd9;
    tick();
    tick();
    chk("tie_lights", 8'({pwin, dwin}), 8'b11);

    // 4: dealer 3 stands on pcard3=8, draws on pcard3=12
    do_reset();
    deal4();
    pscore = 4'd3;
    dscore = 4'd3;
    pulse("p3b", L_P3);
    pcard3 = 4'd8;
    pscore = 4'd1;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("d3v8_load", 8'(loads), 8'(L_NONE));
    chk("d3v8_done", 8'(done), 8'd1);
    tick();
    chk("d3v8_lights", 8'({pwin, dwin}), 8'b01);
    do_reset();
    deal4();
    pscore = 4'd3;
    dscore = 4'd3;
    pulse("p3c", L_P3);
    pcard3 = 4'd12;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("d3vK_load", 8'(loads), 8'(L_D3));

    // dealer 7 always stands after player draws
    do_reset();
    deal4();
    pscore = 4'd2;
    dscore = 4'd7;
    pulse("p3d", L_P3);
    pcard3 = 4'd6;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("d7_load", 8'(loads), 8'(L_NONE));
    chk("d7_done", 8'(done), 8'd1);

    // 5: player stands on 7, dealer 5 draws
    do_reset();
    deal4();
    pscore = 4'd7;
    dscore = 4'd5;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("p7d5_load", 8'(loads), 8'(L_D3));
    chk("p7d5_done", 8'(done), 8'd1);

    // both stand on 6/7
    do_reset();
    deal4();
    pscore = 4'd6;
    dscore = 4'd7;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("p6d7_load", 8'(loads), 8'(L_NONE));
    chk("p6d7_done", 8'(done), 8'd1);
    tick();
    chk("p6d7_lights", 8'({pwin, dwin}), 8'b01);

    // 6: step held two cycles gives one load
    do_reset();
    step = 1'b1;
    tick();
    chk("b2b_first", 8'(loads), 8'(L_P1));
    tick();
    step = 1'b0;
    chk("b2b_second", 8'(loads), 8'(L_NONE));
    tick();
    pulse("b2b_next", L_D1);
    // now in DEAL_P2: reset beats a simultaneous step
    reset = 1'b1;
    step = 1'b1;
    tick();
    reset = 1'b0;
    step = 1'b0;
    chk("mid_rst_loads", 8'(loads), 8'(L_NONE));
    chk("mid_rst_done", 8'(done), 8'd0);
    chk("mid_rst_lights", 8'({pwin, dwin}), 8'd0);
    tick();
    pulse("after_rst", L_P1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
